// File: rtl/branch_ctrl.sv
// branch_ctrl: control-transfer sequencer feeding the program counter.
// Decodes a control op, evaluates its condition and, one cycle later,
// presents a relative or absolute transfer while squashing the
// fall-through instruction fetched in that cycle.
// Optional feature macro: BRANCH_CTRL_RETSTACK_EN enables the return-address
// stack and CALL/RET semantics; without it CALL acts as JMP and RET as NOP.
module branch_ctrl #(
    parameter int D     = 12,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [2:0]          op,
    input  logic                cond_flag,
    input  logic signed [D-1:0] offset,
    input  logic [D-1:0]        abs_addr,
    input  logic [D-1:0]        prog_ctr,
    output logic                branch_en,
    output logic                reljump_en,
    output logic                absjump_en,
    output logic [D-1:0]        target,
    output logic                squash,
    output logic                stack_ovf,
    output logic                stack_unf
);

    localparam logic [2:0] OP_BRZ  = 3'b001;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_BRNZ = 3'b101;

    typedef enum logic {RUN = 1'b0, XFER = 1'b1} state_t;

    state_t         state_p0, state_nxt;
    logic           take;
    logic           rel_sel;
    logic [D-1:0]   tgt_nxt;

    // The PC adds the target to pc_N+1, so the stored displacement is offset-1.
    function automatic logic [D-1:0] rel_target(input logic signed [D-1:0] off);
        return $unsigned(off) - {{(D-1){1'b0}}, 1'b1};
    endfunction

`ifdef BRANCH_CTRL_RETSTACK_EN
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [D-1:0]  stk_mem [DEPTH];
    logic [CW-1:0] stk_cnt_p0;
    logic [CW-1:0] stk_top_idx;
    logic          stk_full;
    logic          stk_empty;
    logic          do_push;
    logic          do_pop;
    logic          set_ovf;
    logic          set_unf;
    logic [D-1:0]  ret_addr;

    assign stk_full    = (stk_cnt_p0 == CW'(DEPTH));
    assign stk_empty   = (stk_cnt_p0 == '0);
    assign stk_top_idx = stk_cnt_p0 - CW'(1);
    assign ret_addr    = prog_ctr + {{(D-1){1'b0}}, 1'b1};
`else
    logic unused_pc;
    assign unused_pc = ^prog_ctr;
`endif

    // Decode the presented op in RUN; XFER ignores the input stream.
    always_comb begin
        take    = 1'b0;
        rel_sel = 1'b0;
        tgt_nxt = '0;
`ifdef BRANCH_CTRL_RETSTACK_EN
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
`endif
        if (state_p0 == RUN && instr_valid) begin
            case (op)
                OP_BRZ: begin
                    if (cond_flag) begin
                        take    = 1'b1;
                        rel_sel = 1'b1;
                        tgt_nxt = rel_target(offset);
                    end
                end
                OP_BRNZ: begin
                    if (!cond_flag) begin
                        take    = 1'b1;
                        rel_sel = 1'b1;
                        tgt_nxt = rel_target(offset);
                    end
                end
                OP_JMP: begin
                    take    = 1'b1;
                    tgt_nxt = abs_addr;
                end
                OP_CALL: begin
                    take    = 1'b1;
                    tgt_nxt = abs_addr;
`ifdef BRANCH_CTRL_RETSTACK_EN
                    if (stk_full) set_ovf = 1'b1;
                    else          do_push = 1'b1;
`endif
                end
                OP_RET: begin
`ifdef BRANCH_CTRL_RETSTACK_EN
                    if (stk_empty) begin
                        set_unf = 1'b1;
                    end else begin
                        take    = 1'b1;
                        do_pop  = 1'b1;
                        tgt_nxt = stk_mem[stk_top_idx[AW-1:0]];
                    end
`endif
                end
                default: ;
            endcase
        end
        state_nxt = take ? XFER : RUN;
    end

    // State register: XFER lasts exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_p0 <= RUN;
        else        state_p0 <= state_nxt;
    end

    // Registered transfer outputs, high only during the XFER cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_en  <= 1'b0;
            reljump_en <= 1'b0;
            absjump_en <= 1'b0;
            squash     <= 1'b0;
            target     <= '0;
        end else begin
            branch_en  <= take;
            reljump_en <= take & rel_sel;
            absjump_en <= take & ~rel_sel;
            squash     <= take;
            target     <= tgt_nxt;
        end
    end

`ifdef BRANCH_CTRL_RETSTACK_EN
    // Stack occupancy and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stk_cnt_p0 <= '0;
            stack_ovf  <= 1'b0;
            stack_unf  <= 1'b0;
        end else begin
            if (do_push)     stk_cnt_p0 <= stk_cnt_p0 + CW'(1);
            else if (do_pop) stk_cnt_p0 <= stk_cnt_p0 - CW'(1);
            if (set_ovf) stack_ovf <= 1'b1;
            if (set_unf) stack_unf <= 1'b1;
        end
    end

    // Return-address storage; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (do_push) stk_mem[stk_cnt_p0[AW-1:0]] <= ret_addr;
    end
`else
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_branch_ctrl;

    localparam int D     = 12;
    localparam int DEPTH = 4;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] BRZ  = 3'b001;
    localparam logic [2:0] JMP  = 3'b010;
    localparam logic [2:0] CALL = 3'b011;
    localparam logic [2:0] RET  = 3'b100;
    localparam logic [2:0] BRNZ = 3'b101;

    logic         clk = 1'b0;
    logic         reset;
    logic         instr_valid;
    logic [2:0]   op;
    logic         cond_flag;
    logic [D-1:0] offset;
    logic [D-1:0] abs_addr;
    logic [D-1:0] prog_ctr;
    logic         branch_en, reljump_en, absjump_en, squash, stack_ovf, stack_unf;
    logic [D-1:0] target;

    int n_tests = 0;
    int n_fail  = 0;

    branch_ctrl #(.D(D), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .op         (op),
        .cond_flag  (cond_flag),
        .offset     (offset),
        .abs_addr   (abs_addr),
        .prog_ctr   (prog_ctr),
        .branch_en  (branch_en),
        .reljump_en (reljump_en),
        .absjump_en (absjump_en),
        .target     (target),
        .squash     (squash),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [D-1:0] m_stk[$];
    bit           m_xfer;
    logic         e_br, e_rel, e_abs, e_sq, e_ovf, e_unf;
    logic [D-1:0] e_tg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stk.delete();
        m_xfer = 0;
        {e_br, e_rel, e_abs, e_sq, e_ovf, e_unf} = '0;
        e_tg = '0;
    endtask

    // Apply the sequencing rules to the inputs seen at this rising edge.
    task automatic model_step();
        bit           tk, rel;
        logic [D-1:0] tg;
        if (!reset) begin
            model_reset();
            return;
        end
        tk = 0; rel = 0; tg = '0;
        if (!m_xfer && instr_valid) begin
            case (op)
                BRZ:  if (cond_flag)  begin tk = 1; rel = 1; tg = offset - D'(1); end
                BRNZ: if (!cond_flag) begin tk = 1; rel = 1; tg = offset - D'(1); end
                JMP:  begin tk = 1; tg = abs_addr; end
                CALL: begin
                    tk = 1; tg = abs_addr;
`ifdef BRANCH_CTRL_RETSTACK_EN
                    if (m_stk.size() < DEPTH) m_stk.push_back(prog_ctr + D'(1));
                    else                      e_ovf = 1'b1;
`endif
                end
                RET: begin
`ifdef BRANCH_CTRL_RETSTACK_EN
                    if (m_stk.size() > 0) begin tk = 1; tg = m_stk.pop_back(); end
                    else                  e_unf = 1'b1;
`endif
                end
                default: ;
            endcase
        end
        m_xfer = tk;
        e_br   = tk;
        e_sq   = tk;
        e_rel  = tk && rel;
        e_abs  = tk && !rel;
        e_tg   = tk ? tg : '0;
    endtask

    // One clock: drive at falling edge, model at rising edge, compare at next falling edge.
    task automatic cyc(input logic v, input logic [2:0] o, input logic c,
                       input logic [D-1:0] off, input logic [D-1:0] a, input logic [D-1:0] pc);
        instr_valid = v; op = o; cond_flag = c; offset = off; abs_addr = a; prog_ctr = pc;
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_cycle",
            {branch_en, reljump_en, absjump_en, squash, stack_ovf, stack_unf, target},
            {e_br, e_rel, e_abs, e_sq, e_ovf, e_unf, e_tg});
    endtask

    initial begin
        int taken;
        reset = 1'b0;
        instr_valid = 0; op = NOP; cond_flag = 0; offset = '0; abs_addr = '0; prog_ctr = '0;
        model_reset();

        // Reset state
        cyc(1, JMP, 0, 12'h000, 12'h555, 12'h000);
        chk("reset_outputs", {branch_en, reljump_en, absjump_en, squash, stack_ovf, stack_unf, target}, 0);
        reset = 1'b1;

        // BRZ taken: target offset-1, PC lands on 0x015
        cyc(1, BRZ, 1, 12'h005, 12'h000, 12'h010);
        chk("brz_flags", {branch_en, reljump_en, absjump_en, squash}, 4'b1101);
        chk("brz_target", target, 12'h004);
        chk("brz_land", D'(12'h011 + target), 12'h015);
        cyc(1, JMP, 0, 12'h000, 12'h777, 12'h011);
        chk("xfer_ignores_op", branch_en, 1'b0);

        // BRNZ with flag set: not taken
        cyc(1, BRNZ, 1, 12'h040, 12'h000, 12'h015);
        chk("brnz_not_taken", {branch_en, squash}, 2'b00);

        // JMP, then CALL in the squashed cycle is ignored
        cyc(1, JMP, 0, 12'h000, 12'hFF0, 12'h016);
        chk("jmp_flags", {branch_en, reljump_en, absjump_en, squash}, 4'b1011);
        chk("jmp_target", target, 12'hFF0);
        cyc(1, CALL, 0, 12'h000, 12'h123, 12'h017);
        chk("squashed_call", branch_en, 1'b0);

        // CALL then RET
        cyc(1, CALL, 0, 12'h000, 12'h100, 12'h020);
        chk("call_target", {absjump_en, target}, {1'b1, 12'h100});
        cyc(0, NOP, 0, 12'h000, 12'h000, 12'h021);
        cyc(1, RET, 0, 12'h000, 12'h000, 12'h100);
`ifdef BRANCH_CTRL_RETSTACK_EN
        chk("ret_target", {branch_en, absjump_en, target}, {2'b11, 12'h021});
`else
        chk("ret_nop", branch_en, 1'b0);
`endif
        cyc(0, NOP, 0, 12'h000, 12'h000, 12'h021);

        // Five CALLs overflow a 4-deep stack; five RETs underflow on the last
        for (int i = 0; i < 5; i++) begin
            cyc(1, CALL, 0, 12'h000, D'(12'h200 + i), D'(12'h030 + i));
            cyc(0, NOP, 0, 12'h000, 12'h000, D'(12'h200 + i));
        end
`ifdef BRANCH_CTRL_RETSTACK_EN
        chk("stack_ovf_set", stack_ovf, 1'b1);
`else
        chk("stack_ovf_tied", stack_ovf, 1'b0);
`endif
        taken = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, RET, 0, 12'h000, 12'h000, D'(12'h300 + i));
            if (branch_en) taken++;
`ifdef BRANCH_CTRL_RETSTACK_EN
            if (i == 0) chk("ret_top_of_stack", target, 12'h034);
`endif
            cyc(0, NOP, 0, 12'h000, 12'h000, D'(12'h301 + i));
        end
`ifdef BRANCH_CTRL_RETSTACK_EN
        chk("ret_taken_count", taken, 4);
        chk("stack_unf_set", stack_unf, 1'b1);
`else
        chk("ret_taken_count", taken, 0);
        chk("stack_unf_tied", stack_unf, 1'b0);
`endif

        // Relative wrap, then asynchronous reset in the XFER cycle
        cyc(1, BRZ, 1, 12'h004, 12'h000, 12'hFFE);
        chk("wrap_target", target, 12'h003);
        chk("wrap_land", D'(12'hFFF + target), 12'h002);
        #1 reset = 1'b0;
        #1 chk("async_reset_clear",
               {branch_en, reljump_en, absjump_en, squash, stack_ovf, stack_unf, target}, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc(1, RET, 0, 12'h000, 12'h000, 12'h000);
        chk("post_reset_ret", branch_en, 1'b0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if (i % 600 == 599) reset = 1'b0;
            cyc(($urandom_range(0, 9) < 7), 3'($urandom), 1'($urandom),
                D'($urandom), D'($urandom), D'($urandom));
            reset = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Control-transfer sequencer that drives the program counter's `branch_en`, `reljump_en`, `absjump_en` and `target` inputs. It decodes a registered control-op stream from the decoder, evaluates the branch condition and issues relative or absolute jumps one cycle later. It also squashes the fall-through instruction fetched in that cycle and maintains a small return-address stack for CALL/RET.

## Interface
- `D`, 12, PC / target width
- `DEPTH`, 4, return-stack entries (power of two, ≥2)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `instr_valid`  in  1  decoded instruction valid this cycle
- `op`  in  3  control op: 000 NOP, 001 BRZ, 010 JMP, 011 CALL, 100 RET, 101 BRNZ, 110/111 NOP
- `cond_flag`  in  1  zero flag from ALU, sampled with `op`
- `offset`  in  D  signed relative displacement (BRZ/BRNZ)
- `abs_addr`  in  D  absolute destination (JMP/CALL)
- `prog_ctr`  in  D  current PC value (address of instruction presented this cycle)
- `branch_en`  out  1  to PC: control transfer this cycle
- `reljump_en`  out  1  to PC: relative transfer
- `absjump_en`  out  1  to PC: absolute transfer
- `target`  out  D  to PC: displacement or destination
- `squash`  out  1  instruction presented this cycle must be discarded by the decoder
- `stack_ovf`  out  1  sticky: CALL issued with stack full
- `stack_unf`  out  1  sticky: RET issued with stack empty

## Operation
- FSM states: RUN, XFER. Reset → RUN.
- RUN: if `instr_valid` and the op is taken → XFER, registering the transfer. Otherwise stay in RUN, with all transfer outputs 0.
- Taken: BRZ if `cond_flag`=1; BRNZ if `cond_flag`=0; JMP and CALL always; RET only if stack non-empty. Anything else is not taken.
- XFER, one cycle, always returns to RUN:
  - `branch_en`=1 and `squash`=1.
  - Exactly one of `reljump_en`/`absjump_en` is 1.
  - `instr_valid` is ignored: no decode, no stack change, no flag change.
- Relative (BRZ/BRNZ): registered `target` = `offset` − 1 mod 2^D. In XFER, `prog_ctr` already equals pc_N+1, so the PC adds `target` and lands on pc_N + `offset`. Wraps mod 2^D.
- JMP: `target` = `abs_addr`.
- CALL:
  - Push pc_N+1 (mod 2^D), then `target` = `abs_addr`.
  - If stack full (count = DEPTH): no push, `stack_ovf` ← 1, jump still taken.
- RET:
  - If stack non-empty: pop top, `target` = popped value, absolute.
  - If empty: not taken, `stack_unf` ← 1, stay RUN, fall through.
- Stack: LIFO, count 0..DEPTH. Push/pop happen at the RUN→XFER edge.
- Sticky flags are cleared only by reset.

## Timing
- Decision latency: op valid in cycle N → transfer outputs high in cycle N+1 → PC loads at the end of N+1 → destination instruction presented in N+2.
- Taken transfer cost: 1 squashed cycle. Not-taken costs 0.
- Back-to-back: a control op is accepted in N+2 immediately after XFER.
- All outputs are registered (no combinational input→output path).
- Reset values: `branch_en`, `reljump_en`, `absjump_en`, `squash`, `stack_ovf`, `stack_unf` = 0; `target` = 0; stack count 0; state RUN.
- Reset asserted mid-XFER: outputs clear asynchronously and the pending transfer is lost. The PC is reset in parallel.
- `instr_valid`=0 in RUN: no state change regardless of `op`.

## Configuration
- `BRANCH_CTRL_RETSTACK_EN` defined: return stack and CALL/RET semantics as above.
- Undefined:
  - No stack storage.
  - CALL behaves exactly as JMP.
  - RET is a not-taken NOP.
  - `stack_ovf` and `stack_unf` are tied 0.

## Test plan
- BRZ with `prog_ctr`=0x010, `offset`=0x005, `cond_flag`=1 → next cycle `branch_en`=`reljump_en`=`squash`=1, `target`=0x004; PC becomes 0x015.
- BRNZ with `cond_flag`=1 → no transfer, `squash` stays 0, PC increments normally.
- JMP `abs_addr`=0xFF0 issued in cycle N, plus a CALL presented in the squashed cycle N+1 → absolute jump to 0xFF0; the CALL is ignored and stack count stays 0.
- CALL 0x100 from PC 0x020, then RET → jump to 0x100, then absolute jump to 0x021.
- Five CALLs with `DEPTH`=4 → `stack_ovf`=1 after the fifth. Then five RETs → four return jumps; the fifth is not taken and sets `stack_unf`=1.
- Relative wrap: `prog_ctr`=0xFFE, `offset`=0x004 → PC lands on 0x002. Then assert reset low mid-XFER → all outputs 0 immediately.
